// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 timing defaults, colour constants and helpers
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_H_DISPLAY_DEF = 640;
    localparam int c_H_FRONT_DEF   = 16;
    localparam int c_H_SYNC_DEF    = 96;
    localparam int c_H_BACK_DEF    = 48;
    localparam int c_H_TOTAL_DEF   = c_H_DISPLAY_DEF + c_H_FRONT_DEF + c_H_SYNC_DEF + c_H_BACK_DEF;

    localparam int c_V_DISPLAY_DEF = 480;
    localparam int c_V_FRONT_DEF   = 10;
    localparam int c_V_SYNC_DEF    = 2;
    localparam int c_V_BACK_DEF    = 33;
    localparam int c_V_TOTAL_DEF   = c_V_DISPLAY_DEF + c_V_FRONT_DEF + c_V_SYNC_DEF + c_V_BACK_DEF;

    localparam int c_PIX_DIV_DEF   = 2;
    localparam bit c_SYNC_POL_DEF  = 1'b0;

    localparam int c_CNT_W = 11;
    typedef logic [c_CNT_W-1:0] coord_t;

    // Bit order [B1 B2 G1 G2 G3 R1 R2 R3]; all-zero is black in every channel.
    localparam logic [7:0] COLOR_NULL = 8'h00;

    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_div
// Description : Pixel-period divider; pix_tick is high while the count is PIX_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_div #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);

    localparam logic [3:0] c_DIV_LAST = 4'(PIX_DIV - 1);

    logic [3:0] r_div;
    logic [3:0] w_div_next;
    logic       r_tick;

    always_comb begin
        w_div_next = (r_div == c_DIV_LAST) ? 4'd0 : r_div + 4'd1;
    end

    // The tick is registered alongside the count so it reads low during reset
    // even when PIX_DIV is 1 and the count already sits at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= 4'd0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == c_DIV_LAST);
        end
    end

    assign pix_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster counters with registered sync/blanking/colour stage
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = c_H_DISPLAY_DEF,
    parameter int H_FRONT   = c_H_FRONT_DEF,
    parameter int H_SYNC    = c_H_SYNC_DEF,
    parameter int H_BACK    = c_H_BACK_DEF,
    parameter int V_DISPLAY = c_V_DISPLAY_DEF,
    parameter int V_FRONT   = c_V_FRONT_DEF,
    parameter int V_SYNC    = c_V_SYNC_DEF,
    parameter int V_BACK    = c_V_BACK_DEF,
    parameter int PIX_DIV   = c_PIX_DIV_DEF,
    parameter bit SYNC_POL  = c_SYNC_POL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rgb_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pix_tick,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [7:0]  rgb_out
);

    localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t c_H_LAST     = coord_t'(c_H_TOTAL - 1);
    localparam coord_t c_V_LAST     = coord_t'(c_V_TOTAL - 1);
    localparam coord_t c_H_VIS      = coord_t'(H_DISPLAY);
    localparam coord_t c_V_VIS      = coord_t'(V_DISPLAY);
    localparam coord_t c_HS_FIRST   = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t c_HS_LAST    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t c_VS_FIRST   = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t c_VS_LAST    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    generate
        if (c_H_TOTAL > 2047 || c_V_TOTAL > 2047) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 2047");
        end
        if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
            $error("vga_sync_gen: PIX_DIV must be in 1..16");
        end
    endgenerate

    logic       w_pix_tick;
    logic       w_x_last;
    logic       w_y_last;
    logic       w_visible;
    coord_t     r_x;
    coord_t     r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic [7:0] r_rgb;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (w_pix_tick)
    );

    assign w_x_last  = (r_x == c_H_LAST);
    assign w_y_last  = (r_y == c_V_LAST);
    assign w_visible = (r_x < c_H_VIS) && (r_y < c_V_VIS);

    // Output stage describes the pixel being left on this tick, giving one
    // pixel period of latency and a full period for the generator's rgb_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= ~SYNC_POL;
            r_vsync    <= ~SYNC_POL;
            r_video_on <= 1'b0;
            r_rgb      <= COLOR_NULL;
        end else if (w_pix_tick) begin
            r_x <= w_x_last ? '0 : r_x + coord_t'(1);
            if (w_x_last) begin
                r_y <= w_y_last ? '0 : r_y + coord_t'(1);
            end
            r_hsync    <= in_window(r_x, c_HS_FIRST, c_HS_LAST) ? SYNC_POL : ~SYNC_POL;
            r_vsync    <= in_window(r_y, c_VS_FIRST, c_VS_LAST) ? SYNC_POL : ~SYNC_POL;
            r_video_on <= w_visible;
            r_rgb      <= w_visible ? rgb_in : COLOR_NULL;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign pix_tick   = w_pix_tick;
    assign frame_tick = w_pix_tick && w_x_last && w_y_last;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign rgb_out    = r_rgb;

endmodule
`default_nettype wire
